// File: rtl/rgb_pwm_out.sv
// Three-channel RGB PWM driver sharing one period counter; duties are latched into shadows at each period end.
// Latency: led_x and period_start are registered, one clock behind the counter; no input-to-output combinational path.
// Backpressure: none; duty inputs are sampled only at period end, or on every clock while disabled.
module rgb_pwm_out #(
    parameter int  PWM_INTERVAL = 1200,
    parameter bit  ACTIVE_LOW   = 1'b1,
    localparam int W            = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] duty_r,
    input  logic [W-1:0] duty_g,
    input  logic [W-1:0] duty_b,
    output logic         led_r,
    output logic         led_g,
    output logic         led_b,
    output logic         period_start
);
    localparam logic [W-1:0] LAST  = W'(PWM_INTERVAL - 1);
    localparam logic         UNLIT = ACTIVE_LOW;

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] sh_r_q, sh_r_d;
    logic [W-1:0] sh_g_q, sh_g_d;
    logic [W-1:0] sh_b_q, sh_b_d;
    logic         led_r_q, led_r_d;
    logic         led_g_q, led_g_d;
    logic         led_b_q, led_b_d;
    logic         ps_q, ps_d;

    always_comb begin
        cnt_d   = cnt_q;
        sh_r_d  = sh_r_q;
        sh_g_d  = sh_g_q;
        sh_b_d  = sh_b_q;
        led_r_d = UNLIT;
        led_g_d = UNLIT;
        led_b_d = UNLIT;
        ps_d    = 1'b0;
        if (!en) begin
            // Disabled: park at period start and keep the shadows tracking the inputs.
            cnt_d  = '0;
            sh_r_d = duty_r;
            sh_g_d = duty_g;
            sh_b_d = duty_b;
        end else begin
            // A shadow >= PWM_INTERVAL exceeds every count, so it stays lit all period.
            led_r_d = (cnt_q < sh_r_q) ^ ACTIVE_LOW;
            led_g_d = (cnt_q < sh_g_q) ^ ACTIVE_LOW;
            led_b_d = (cnt_q < sh_b_q) ^ ACTIVE_LOW;
            ps_d    = (cnt_q == '0);
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                sh_r_d = duty_r;
                sh_g_d = duty_g;
                sh_b_d = duty_b;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sh_r_q  <= '0;
            sh_g_q  <= '0;
            sh_b_q  <= '0;
            led_r_q <= UNLIT;
            led_g_q <= UNLIT;
            led_b_q <= UNLIT;
            ps_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sh_r_q  <= sh_r_d;
            sh_g_q  <= sh_g_d;
            sh_b_q  <= sh_b_d;
            led_r_q <= led_r_d;
            led_g_q <= led_g_d;
            led_b_q <= led_b_d;
            ps_q    <= ps_d;
        end
    end

    assign led_r        = led_r_q;
    assign led_g        = led_g_q;
    assign led_b        = led_b_q;
    assign period_start = ps_q;
endmodule

// File: tb/tb_rgb_pwm_out.sv
// Bench for rgb_pwm_out: an active-low and an active-high instance share stimulus, checked every cycle against a period/phase model.
module tb_rgb_pwm_out;
    localparam int PI = 10;
    localparam int W  = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         en    = 1'b0;
    logic [W-1:0] duty_r = '0, duty_g = '0, duty_b = '0;
    logic         led_r1, led_g1, led_b1, ps1;
    logic         led_r2, led_g2, led_b2, ps2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rgb_pwm_out #(.PWM_INTERVAL(PI), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .led_r(led_r1), .led_g(led_g1), .led_b(led_b1), .period_start(ps1)
    );

    rgb_pwm_out #(.PWM_INTERVAL(PI), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .en(en),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .led_r(led_r2), .led_g(led_g2), .led_b(led_b2), .period_start(ps2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: phase within the period and the on-time committed for that period.
    int phase     = 0;
    int ontime[3] = '{0, 0, 0};
    bit m_on[3]   = '{0, 0, 0};
    bit m_ps      = 0;

    function automatic int clip(input int d);
        return (d > PI) ? PI : d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0;
            ontime = '{0, 0, 0};
            m_on = '{0, 0, 0};
            m_ps = 0;
        end else if (!en) begin
            phase = 0;
            ontime = '{clip(int'(duty_r)), clip(int'(duty_g)), clip(int'(duty_b))};
            m_on = '{0, 0, 0};
            m_ps = 0;
        end else begin
            for (int c = 0; c < 3; c++) m_on[c] = (phase < ontime[c]);
            m_ps = (phase == 0);
            phase = (phase + 1) % PI;
            if (phase == 0)
                ontime = '{clip(int'(duty_r)), clip(int'(duty_g)), clip(int'(duty_b))};
        end
    end

    always @(negedge clk) begin
        chk("ps_lo", int'(ps1), int'(m_ps));
        chk("ps_hi", int'(ps2), int'(m_ps));
        chk("led_r_lo", int'(led_r1), int'(!m_on[0]));
        chk("led_g_lo", int'(led_g1), int'(!m_on[1]));
        chk("led_b_lo", int'(led_b1), int'(!m_on[2]));
        chk("led_r_hi", int'(led_r2), int'(m_on[0]));
        chk("led_g_hi", int'(led_g2), int'(m_on[1]));
        chk("led_b_hi", int'(led_b2), int'(m_on[2]));
    end

    // Waits for period_start, then records which of the period's 10 clocks are lit.
    task automatic measure(input int chg_at, input logic [W-1:0] chg_val, output int waited,
                           output logic [9:0] mr, output logic [9:0] mg,
                           output logic [9:0] mb, output logic [9:0] m2r);
        waited = 0; mr = '0; mg = '0; mb = '0; m2r = '0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ps1 && waited < 40);
        if (!ps1) begin
            chk("ps_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < PI; i++) begin
            if (i > 0) @(negedge clk);
            if (i == chg_at) duty_g = chg_val;
            mr[i]  = (led_r1 == 1'b0);
            mg[i]  = (led_g1 == 1'b0);
            mb[i]  = (led_b1 == 1'b0);
            m2r[i] = (led_r2 == 1'b1);
        end
    endtask

    task automatic unlit_now(input string name);
        chk({name, "_r_lo"}, int'(led_r1), 1);
        chk({name, "_g_lo"}, int'(led_g1), 1);
        chk({name, "_b_lo"}, int'(led_b1), 1);
        chk({name, "_r_hi"}, int'(led_r2), 0);
        chk({name, "_ps"},   int'(ps1),    0);
    endtask

    initial begin
        int w;
        logic [9:0] mr, mg, mb, m2r;

        #1 rst_n = 1'b0;
        #1 unlit_now("reset_async");
        repeat (2) @(posedge clk);
        #1;
        en = 1'b1; duty_r = 4'd3; duty_g = 4'd3; duty_b = 4'd0;
        rst_n = 1'b1;

        // Steady duty 3: first period runs on the reset shadows, the second on 3.
        measure(-1, '0, w, mr, mg, mb, m2r);
        chk("first_period_r", int'(mr), 0);
        measure(-1, '0, w, mr, mg, mb, m2r);
        chk("steady_r3", int'(mr), 10'h007);
        chk("steady_g3", int'(mg), 10'h007);
        chk("duty0_b", int'(mb), 10'h000);
        chk("hi_pol_r3", int'(m2r), 10'h007);
        measure(-1, '0, w, mr, mg, mb, m2r);
        chk("steady_r3_next", int'(mr), 10'h007);
        chk("steady_period_gap", w, 1);

        // duty_g 3 -> 6 while the counter is at 4.
        measure(3, 4'd6, w, mr, mg, mb, m2r);
        chk("midchg_cur_g", int'(mg), 10'h007);
        measure(-1, '0, w, mr, mg, mb, m2r);
        chk("midchg_next_g", int'(mg), 10'h03F);

        duty_b = 4'd9; duty_r = 4'd4;
        measure(-1, '0, w, mr, mg, mb, m2r);
        measure(-1, '0, w, mr, mg, mb, m2r);
        chk("duty9_b", int'(mb), 10'h1FF);
        chk("hi_pol_r4", int'(m2r), 10'h00F);

        duty_b = 4'd15;
        measure(-1, '0, w, mr, mg, mb, m2r);
        measure(-1, '0, w, mr, mg, mb, m2r);
        chk("duty15_b_a", int'(mb), 10'h3FF);
        measure(-1, '0, w, mr, mg, mb, m2r);
        chk("duty15_b_b", int'(mb), 10'h3FF);

        // Drop enable mid-period.
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        unlit_now("en_drop");
        repeat (12) @(negedge clk);
        unlit_now("en_low_hold");

        // Raise enable with duty_r 5.
        duty_r = 4'd5;
        @(negedge clk);
        en = 1'b1;
        measure(-1, '0, w, mr, mg, mb, m2r);
        chk("en_rise_ps_delay", w, 1);
        chk("en_rise_r5", int'(mr), 10'h01F);

        // Asynchronous reset mid-period, between clock edges.
        measure(-1, '0, w, mr, mg, mb, m2r);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 unlit_now("reset_mid");
        @(posedge clk);
        #1 rst_n = 1'b1;
        measure(-1, '0, w, mr, mg, mb, m2r);
        chk("post_reset_r", int'(mr), 0);
        measure(-1, '0, w, mr, mg, mb, m2r);
        chk("post_reset_r5", int'(mr), 10'h01F);

        // Randomized traffic checked by the per-cycle model.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(3, 0) == 0) duty_r = W'($urandom_range(15, 0));
            if ($urandom_range(3, 0) == 0) duty_g = W'($urandom_range(15, 0));
            if ($urandom_range(3, 0) == 0) duty_b = W'($urandom_range(15, 0));
            if ($urandom_range(39, 0) == 0) en = ~en;
            if ($urandom_range(299, 0) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
